mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Unified instruction/data memory port for the multicycle RISC-V datapath, directly downstream of the control FSM.
//  Turns the FSM memory controls (IorD, MemWrite, IRWrite, func3) into a valid/ready bus transaction.
//  Owns the Instruction Register and the Memory Data Register, with byte/half lane steering and load extension.
//  Returns mem_busy so the FSM and PC hold their state until the access completes.
// PARAMETERS
//  TIMEOUT   255  max ACCESS cycles waiting for bus_ready before a timeout error; range 1..255
//  NOP_INSTR 32'h0000_0013  IR reset value (addi x0,x0,0)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  mem_req    in   1   FSM is in a memory state (FETCH/MEM_READ/MEM_WRITE); level, held while mem_busy=1
//  IorD       in   1   address select: 0=pc (fetch), 1=alu_out (data)
//  MemWrite   in   1   1=store, 0=read
//  IRWrite    in   1   1=read result loads IR, 0=loads MDR
//  func3      in   3   data size/sign (RV32I load/store encoding); ignored for fetch
//  pc         in   32  program counter
//  alu_out    in   32  registered data address
//  wdata      in   32  store data (rs2)
//  bus_valid  out  1   request valid; held until bus_ready
//  bus_we     out  1   write strobe
//  bus_addr   out  32  word-aligned address ({addr[31:2],2'b00})
//  bus_be     out  4   byte enables
//  bus_wdata  out  32  lane-steered store data
//  bus_ready  in   1   memory accepts/completes the access this cycle
//  bus_rdata  in   32  read data, valid when bus_ready=1 and bus_we=0
//  instr      out  32  Instruction Register
//  mdr        out  32  Memory Data Register (extended load data)
//  mem_busy   out  1   stall to FSM
//  err        out  1   sticky error
//  err_code   out  2   00 none, 01 misaligned, 10 timeout, 11 illegal func3
// BEHAVIOUR
//  Reset (async): state=IDLE; bus_valid=0; bus_we=0; bus_addr=0; bus_be=0; bus_wdata=0; instr=NOP_INSTR; mdr=0; err=0; err_code=00; timeout counter=0.
//   Reset asserted mid-access drops bus_valid immediately and abandons the transaction.
//  States: IDLE, ACCESS, DONE, ERROR.
//  IDLE:
//   - mem_req=1 captures addr (IorD ? alu_out : pc), we=MemWrite&IorD, be, wdata, func3, and the IR/MDR target.
//   - Then ->ACCESS with bus_valid=1 from the next cycle; if the checks fail, ->ERROR with no bus request.
//   - mem_req=0: stay in IDLE.
//  Checks, in priority order:
//   - Fetch with pc[1:0]!=0 -> misaligned.
//   - Data with func3 in {011,110,111}, or a store with func3 in {100,101} -> illegal.
//   - Half with addr[0]!=0, or word with addr[1:0]!=0 -> misaligned.
//  ACCESS:
//   - All bus outputs stay stable while waiting.
//   - On bus_ready=1: ->DONE. A read captures into IR (IRWrite=1) or MDR (IRWrite=0) at that edge.
//   - Timeout counter starts at 0 on ACCESS entry and increments each cycle without bus_ready.
//   - A cycle where counter==TIMEOUT-1 and bus_ready=0 -> ERROR with code 10.
//  DONE: bus_valid=0; mem_busy=0 for one cycle so the FSM advances; ->IDLE unconditionally (mem_req ignored in DONE).
//  ERROR: terminal until reset; mem_busy=1; bus_valid=0; err=1; err_code holds the first error.
//  mem_busy = (state==IDLE & mem_req) | ACCESS | ERROR (combinational).
//  Minimum latency: mem_req rises (IDLE) -> ACCESS with bus_ready=1 -> DONE, i.e. mem_busy low in the 3rd cycle.
//  Back-to-back accesses are separated by one IDLE cycle.
//  Store steering, a=addr[1:0]:
//   - sb: wdata[7:0] replicated x4, be=4'b0001<<a.
//   - sh: wdata[15:0] replicated x2, be = a[1] ? 4'b1100 : 4'b0011.
//   - sw: wdata, be=4'b1111.
//  Read be=4'b1111.
//  Load extract from bus_rdata lane a:
//   - lb: sign-extend byte; lbu: zero-extend byte.
//   - lh: sign-extend half; lhu: zero-extend half.
//   - lw: full word.
//  instr and mdr hold their value until the next completed read of their kind. Stores never modify either.
// TESTING
//  Fetch: pc=0x10, bus_ready on 1st ACCESS cycle, rdata=0x00500093 -> bus_addr=0x10, be=F; instr=0x00500093; mem_busy low in cycle 3.
//  Wait states: lw at 0x104, bus_ready after 4 cycles -> bus_valid/addr stable 4 cycles; mdr=rdata; one DONE cycle.
//  Sub-word load: lb at 0x203, rdata=0x80FF_0000 -> mdr=0xFFFF_FF80; lhu at 0x202 -> mdr=0x0000_80FF.
//  Store: sb at 0x301, wdata=0x1234_56AB -> bus_we=1, be=0010, bus_wdata=0xABAB_ABAB, bus_addr=0x300; instr/mdr unchanged.
//  Errors: lw at 0x102 -> no bus_valid, err_code=01, mem_busy stuck 1. bus_ready never -> err_code=10 after 255 ACCESS cycles.
//  Reset in ACCESS: rst low -> bus_valid=0 same cycle, instr=0x00000013, err cleared; next mem_req starts a fresh access.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - unified instruction/data memory port with IR/MDR, lane steering and load extension
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-low reset
//   mem_req                     FSM is in a memory state; held while mem_busy=1
//   IorD, MemWrite, IRWrite     FSM memory controls (address select, store, IR/MDR target)
//   func3                       RV32I load/store size/sign encoding (ignored for fetch)
//   pc, alu_out, wdata          fetch address, data address, store data
//   bus_valid/we/addr/be/wdata  request side of the valid/ready memory bus
//   bus_ready, bus_rdata        completion handshake and read data
//   instr, mdr                  Instruction Register, Memory Data Register
//   mem_busy                    stall to FSM/PC
//   err, err_code               sticky error and first error cause (01 misaligned, 10 timeout, 11 illegal)
module mem_access_unit #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        IorD,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic [2:0]  func3,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] wdata,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [31:0] instr,
    output logic [31:0] mdr,
    output logic        mem_busy,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Request captured at IDLE->ACCESS; kept for read-data extraction.
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        to_ir_q;
    logic [7:0]  tmo_cnt;

    // Request decode, evaluated while IDLE.
    logic [31:0] req_addr;
    logic [2:0]  req_f3;
    logic        req_we;
    logic [1:0]  req_a;
    logic [1:0]  chk_code;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    assign req_addr = IorD ? alu_out : pc;
    // A fetch is always a full word regardless of func3.
    assign req_f3   = IorD ? func3 : 3'b010;
    assign req_we   = MemWrite & IorD;
    assign req_a    = req_addr[1:0];

    always_comb begin
        chk_code = 2'b00;
        if (!IorD) begin
            if (pc[1:0] != 2'b00)
                chk_code = 2'b01;
        end else if (func3 == 3'b011 || func3[2:1] == 2'b11 ||
                     (MemWrite && func3[2:1] == 2'b10)) begin
            chk_code = 2'b11;
        end else if ((func3[1:0] == 2'b01 && alu_out[0]) ||
                     (func3[1:0] == 2'b10 && alu_out[1:0] != 2'b00)) begin
            chk_code = 2'b01;
        end
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata;
        if (req_we) begin
            case (func3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << req_a;
                    st_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = req_a[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load extraction from the lane chosen by the captured byte offset.
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;

    always_comb begin
        case (off_q)
            2'd0:    lane_byte = bus_rdata[7:0];
            2'd1:    lane_byte = bus_rdata[15:8];
            2'd2:    lane_byte = bus_rdata[23:16];
            default: lane_byte = bus_rdata[31:24];
        endcase
        lane_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_val = {24'd0, lane_byte};
            3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_val = {16'd0, lane_half};
            default: load_val = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus_valid = 1'b0;
        err       = 1'b0;
        mem_busy  = 1'b0;
        case (state)
            S_IDLE: begin
                mem_busy = mem_req;
                if (mem_req)
                    state_nxt = (chk_code != 2'b00) ? S_ERROR : S_ACCESS;
            end
            S_ACCESS: begin
                bus_valid = 1'b1;
                mem_busy  = 1'b1;
                if (bus_ready)
                    state_nxt = S_DONE;
                else if (tmo_cnt == TMO_LAST)
                    state_nxt = S_ERROR;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                mem_busy = 1'b1;
                err      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            to_ir_q   <= 1'b0;
            tmo_cnt   <= 8'd0;
            instr     <= NOP_INSTR;
            mdr       <= 32'd0;
            err_code  <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    tmo_cnt <= 8'd0;
                    if (mem_req) begin
                        if (chk_code == 2'b00) begin
                            bus_we    <= req_we;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= st_be;
                            bus_wdata <= st_wdata;
                            f3_q      <= req_f3;
                            off_q     <= req_a;
                            to_ir_q   <= IRWrite;
                        end else begin
                            err_code  <= chk_code;
                        end
                    end
                end
                S_ACCESS: begin
                    if (bus_ready) begin
                        if (!bus_we) begin
                            if (to_ir_q)
                                instr <= load_val;
                            else
                                mdr   <= load_val;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_code <= 2'b10;
                    end else begin
                        tmo_cnt  <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, IorD, MemWrite, IRWrite;
    logic [2:0]  func3;
    logic [31:0] pc, alu_out, wdata;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [31:0] instr, mdr;
    logic        mem_busy, err;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_instr, exp_mdr;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .func3(func3), .pc(pc), .alu_out(alu_out), .wdata(wdata),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .instr(instr), .mdr(mdr), .mem_busy(mem_busy), .err(err), .err_code(err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: expected error code of a request (0 = legal).
    function automatic logic [1:0] model_chk(input logic iord, input logic mw,
                                             input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        if (!iord) return (addr % 4 != 0) ? 2'b01 : 2'b00;
        if (f3 == 3 || f3 == 6 || f3 == 7) return 2'b11;
        if (mw && (f3 == 4 || f3 == 5)) return 2'b11;
        sz = int'(f3) % 4;
        if (sz == 1 && addr % 2 != 0) return 2'b01;
        if (sz == 2 && addr % 4 != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rd);
        logic [31:0] v;
        int a;
        a = int'(addr % 4);
        case (f3)
            3'd0, 3'd4: begin
                v = (rd >> (8 * a)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (rd >> (8 * (a - a % 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                               output logic [3:0] be, output logic [31:0] ewd);
        int a;
        a = int'(addr % 4);
        case (int'(f3) % 4)
            0: begin be = 4'(1 << a);       ewd = (wd & 32'hFF) * 32'h0101_0101; end
            1: begin be = 4'(3 << a);       ewd = (wd & 32'hFFFF) * 32'h0001_0001; end
            default: begin be = 4'hF;       ewd = wd; end
        endcase
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_valid", bus_valid, 0);
        check("rst_we", bus_we, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_be", bus_be, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_instr", instr, 32'h13);
        check("rst_mdr", mdr, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        exp_instr = 32'h13;
        exp_mdr   = 32'h0;
        mem_req = 0; bus_ready = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", mem_busy, 0);
    endtask

    // One full access; inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic access(input logic iord, input logic mw, input logic irw, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int waits,
                          input logic [31:0] rd);
        logic [1:0]  ec;
        logic [3:0]  ebe;
        logic [31:0] ewd, eaddr;
        logic        we;
        ec = model_chk(iord, mw, f3, addr);
        we = mw & iord;
        eaddr = addr - (addr % 4);
        IorD = iord; MemWrite = mw; IRWrite = irw; func3 = f3; wdata = wd;
        if (iord) alu_out = addr; else pc = addr;
        mem_req = 1'b1;
        #1;
        check("idle_busy", mem_busy, 1);
        @(posedge clk); #1;
        if (ec != 2'b00) begin
            check("err_valid", bus_valid, 0);
            check("err_flag", err, 1);
            check("err_code", err_code, ec);
            mem_req = 1'b0;
            @(posedge clk); #1;
            check("err_busy_stuck", mem_busy, 1);
            check("err_valid_hold", bus_valid, 0);
            return;
        end
        if (we) model_store(f3, addr, wd, ebe, ewd);
        else begin ebe = 4'hF; ewd = 32'h0; end
        check("acc_valid", bus_valid, 1);
        check("acc_we", bus_we, we);
        check("acc_addr", bus_addr, eaddr);
        check("acc_be", bus_be, ebe);
        if (we) check("acc_wdata", bus_wdata, ewd);
        check("acc_busy", mem_busy, 1);
        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
            check("wait_valid", bus_valid, 1);
            check("wait_addr", bus_addr, eaddr);
            check("wait_be", bus_be, ebe);
        end
        bus_ready = 1'b1;
        bus_rdata = rd;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        if (!we) begin
            if (irw) exp_instr = model_load(iord ? f3 : 3'd2, addr, rd);
            else     exp_mdr   = model_load(iord ? f3 : 3'd2, addr, rd);
        end
        check("done_busy", mem_busy, 0);
        check("done_valid", bus_valid, 0);
        check("done_instr", instr, exp_instr);
        check("done_mdr", mdr, exp_mdr);
        mem_req = 1'b0;
        @(posedge clk); #1;
        check("idle_after", mem_busy, 0);
        check("idle_valid", bus_valid, 0);
    endtask

    initial begin
        int bad;
        int kind;
        logic [2:0] f3;
        logic [31:0] ad;
        logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst = 1'b1; mem_req = 0; IorD = 0; MemWrite = 0; IRWrite = 0; func3 = 0;
        pc = 0; alu_out = 0; wdata = 0; bus_ready = 0; bus_rdata = 0;
        apply_reset();

        // Directed: fetch, wait states, sub-word loads, byte store.
        access(1'b0, 1'b0, 1'b1, 3'd0, 32'h10,  32'h0,          0, 32'h0050_0093);
        check("fetch_instr", instr, 32'h0050_0093);
        access(1'b1, 1'b0, 1'b0, 3'd2, 32'h104, 32'h0,          3, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 1'b0, 3'd0, 32'h203, 32'h0,          0, 32'h80FF_0000);
        check("lb_mdr", mdr, 32'hFFFF_FF80);
        access(1'b1, 1'b0, 1'b0, 3'd5, 32'h202, 32'h0,          1, 32'h80FF_0000);
        check("lhu_mdr", mdr, 32'h0000_80FF);
        access(1'b1, 1'b1, 1'b0, 3'd0, 32'h301, 32'h1234_56AB,  2, 32'hDEAD_BEEF);
        check("sb_mdr_kept", mdr, 32'h0000_80FF);

        // Randomized legal accesses against the model.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            ad = $urandom;
            if (kind == 0) begin
                access(1'b0, 1'b0, 1'b1, 3'($urandom), {ad[31:2], 2'b00}, 32'h0,
                       $urandom_range(0, 3), $urandom);
            end else if (kind == 1) begin
                f3 = ld_f3[$urandom_range(0, 4)];
                if (f3[1:0] == 2'b01) ad[0] = 1'b0;
                if (f3[1:0] == 2'b10) ad[1:0] = 2'b00;
                access(1'b1, 1'b0, 1'($urandom), f3, ad, 32'h0, $urandom_range(0, 3), $urandom);
            end else begin
                f3 = 3'($urandom_range(0, 2));
                if (f3 == 3'd1) ad[0] = 1'b0;
                if (f3 == 3'd2) ad[1:0] = 2'b00;
                access(1'b1, 1'b1, 1'b0, f3, ad, $urandom, $urandom_range(0, 3), $urandom);
            end
        end

        // Errors: each leaves the unit stuck until reset.
        access(1'b1, 1'b0, 1'b0, 3'd2, 32'h102, 32'h0, 0, 32'h0);
        apply_reset();
        access(1'b1, 1'b1, 1'b0, 3'd4, 32'h100, 32'h0, 0, 32'h0);
        apply_reset();
        access(1'b0, 1'b0, 1'b1, 3'd0, 32'h12,  32'h0, 0, 32'h0);
        apply_reset();
        access(1'b1, 1'b0, 1'b0, 3'd7, 32'h100, 32'h0, 0, 32'h0);
        apply_reset();

        // Timeout: 255 ACCESS cycles without bus_ready.
        IorD = 1; MemWrite = 0; IRWrite = 0; func3 = 3'd2; alu_out = 32'h400; mem_req = 1;
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 254; i++) begin
            if (bus_valid !== 1'b1 || err !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("tmo_waiting", 32'(bad), 0);
        check("tmo_last_valid", bus_valid, 1);
        @(posedge clk); #1;
        check("tmo_err", err, 1);
        check("tmo_code", err_code, 2'b10);
        check("tmo_valid", bus_valid, 0);
        check("tmo_busy", mem_busy, 1);
        mem_req = 0;
        apply_reset();

        // Reset while an access is outstanding.
        access(1'b0, 1'b0, 1'b1, 3'd0, 32'h20, 32'h0, 0, 32'h1234_5678);
        IorD = 1; MemWrite = 0; IRWrite = 0; func3 = 3'd2; alu_out = 32'h500; mem_req = 1;
        @(posedge clk); #1;
        check("mid_valid_pre", bus_valid, 1);
        rst = 1'b0;
        #1;
        check("mid_valid", bus_valid, 0);
        check("mid_instr", instr, 32'h13);
        check("mid_err", err, 0);
        exp_instr = 32'h13; exp_mdr = 32'h0;
        mem_req = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 1'b0, 3'd4, 32'h601, 32'h0, 1, 32'h0000_C300);
        check("fresh_mdr", mdr, 32'h0000_00C3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
